// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the uart_tx transmitter and the io_rx receiver:
//   the serial FSM state encoding, the payload width and the baud divider
//   helper.
// Optional feature macro used by the consumers of this package:
//   UART_TX_PARITY_EN  -- adds an even-parity bit after the data bits.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // Clock cycles per bit time, truncated (40 MHz / 115200 -> 347).
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
//   Byte push bus between the CPU and the UART transmitter FIFO.
//   tx_data  : byte to send
//   tx_valid : tx_data is valid this cycle
//   tx_ready : transmitter can accept a byte this cycle
//   A byte is transferred on every rising edge where tx_valid && tx_ready.
//   master : the CPU side (drives data/valid)
//   slave  : the transmitter side (drives ready)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface : uart_tx_if

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Synchronous FIFO with a show-ahead head: dout always presents the oldest
//   entry while empty is low, and pop simply advances past it.
// Parameters:
//   WIDTH : entry width in bits
//   DEPTH : number of entries, power of two and >= 2
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset (empties the FIFO)
//   push, din    : write din when push is high and the FIFO is not full
//   pop          : drop the head entry when pop is high and not empty
//   dout         : head entry (valid while empty is low)
//   full, empty  : occupancy flags
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates "full" from "empty" when the index bits
  // are equal; the pointers then wrap naturally with no modulo logic.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign dout = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; emptying the FIFO only
  // needs the pointers, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule : uart_tx_fifo

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   Byte-oriented UART transmitter. Bytes pushed over the uart_tx_if bus are
//   queued in a small FIFO and sent LSB first as 8N1/8N2 frames (8E1/8E2 with
//   parity) on io_tx. Back-to-back frames are sent with no idle gap.
// Parameters:
//   CLK_FREQ_HZ : system clock frequency
//   BAUD        : line rate; bit time = CLK_FREQ_HZ/BAUD cycles (truncated)
//   FIFO_DEPTH  : TX FIFO entries, power of two and >= 2
//   STOP_BITS   : 1 or 2
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset; aborts any frame, line high
//   bus     : uart_tx_if.slave (tx_data, tx_valid, tx_ready = !fifo_full)
//   io_tx   : serial line, idle high
//   tx_busy : registered; FIFO non-empty or a frame in progress
// Configuration macro:
//   UART_TX_PARITY_EN : insert an even-parity bit (^data) after the data bits.
// Timing: a byte accepted at edge N into an empty FIFO is popped at N+1 and
//   io_tx falls at N+2 (io_tx is a register fed by the FSM state).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 40_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4,
  parameter int STOP_BITS   = 1
) (
  input  logic      clk,
  input  logic      reset_n,
  uart_tx_if.slave  bus,
  output logic      io_tx,
  output logic      tx_busy
);

  localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);
  localparam logic [2:0]    DATA_LAST = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'(IDLE);
  localparam logic [2:0] S_START  = 3'(START);
  localparam logic [2:0] S_DATA   = 3'(DATA);
  localparam logic [2:0] S_STOP   = 3'(STOP);
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'(PARITY);
`endif

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_dout;

  assign bus.tx_ready = !fifo_full;
  assign fifo_push    = bus.tx_valid && !fifo_full;

  uart_tx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (bus.tx_data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Serial FSM
  // ---------------------------------------------------------------------------
  logic [2:0]                state;
  logic [2:0]                state_next;
  logic [CW-1:0]             baud_cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      line;
  logic                      io_tx_q;
  logic                      busy_q;
  logic                      bit_done;
  logic                      stop_last;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q;
`endif

  assign bit_done  = (baud_cnt == BAUD_LAST);
  // bit_idx doubles as the stop-bit counter while in STOP.
  assign stop_last = bit_done && (bit_idx == STOP_LAST);

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    line       = 1'b1;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        line = 1'b0;
        if (bit_done) state_next = S_DATA;
      end
      S_DATA: begin
        line = shift[0];
        if (bit_done && (bit_idx == DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        line = parity_q;
        if (bit_done) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        line = 1'b1;
        if (stop_last) begin
          // Chain straight into the next frame so there is no idle gap.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      io_tx_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state   <= state_next;
      io_tx_q <= line;
      busy_q  <= (state_next != S_IDLE) || !fifo_empty;

      // Every state change other than leaving IDLE coincides with bit_done,
      // so the counter restarts at 0 at the start of each bit time.
      if ((state == S_IDLE) || bit_done) baud_cnt <= '0;
      else                               baud_cnt <= baud_cnt + 1'b1;

      if (state_next != state) bit_idx <= '0;
      else if (bit_done)       bit_idx <= bit_idx + 1'b1;

      if (fifo_pop)
        shift <= fifo_dout;
      else if ((state == S_DATA) && bit_done)
        shift <= {1'b0, shift[UART_DATA_BITS-1:1]};
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is latched with the byte because the shift register is consumed
  // while the data bits go out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      parity_q <= 1'b0;
    else if (fifo_pop) parity_q <= ^fifo_dout;
  end
`endif

  assign io_tx   = io_tx_q;
  assign tx_busy = busy_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Self-checking bench for uart_tx at 40 MHz / 115200 baud (347 clks/bit).
//   Pushed bytes go into a scoreboard queue; a line monitor decodes every
//   frame at mid-bit and compares it with the scoreboard head.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx;

  localparam int CPB       = 347;
  localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 10 + STOP_BITS - 1 + PAR;
  localparam int FRAME = NBITS * CPB;
  localparam logic [11:0] MASK = 12'((1 << NBITS) - 1);

  logic clk = 1'b0;
  logic reset_n;
  logic io_tx;
  logic tx_busy;

  uart_tx_if bus ();

  uart_tx #(
    .CLK_FREQ_HZ (40_000_000),
    .BAUD        (115200),
    .FIFO_DEPTH  (4),
    .STOP_BITS   (STOP_BITS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .io_tx   (io_tx),
    .tx_busy (tx_busy)
  );

  always #12.5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         fall_q[$];
  logic       par_q[$];
  logic       mon_busy  = 1'b0;
  logic       rst_seen  = 1'b0;
  int         mon_frames = 0;

  always @(negedge reset_n) rst_seen = 1'b1;

  // Expected line bits of one frame, index 0 = start bit.
  function automatic logic [11:0] model_frame(input logic [7:0] b);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Line monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [11:0] bits;
    logic [7:0]  exp_b;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n === 1'b1 && io_tx === 1'b0) begin
        mon_busy = 1'b1;
        rst_seen = 1'b0;
        fall_q.push_back(cyc);
        bits = '1;
        step(CPB / 2);
        bits[0] = io_tx;
        for (int i = 1; i < NBITS; i++) begin
          step(CPB);
          bits[i] = io_tx;
        end
        if (!rst_seen) begin
          mon_frames++;
          par_q.push_back(bits[9]);
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: got frame bits %h, required no frame", bits & MASK);
          end else begin
            exp_b = sb.pop_front();
            if (((bits ^ model_frame(exp_b)) & MASK) != 12'd0) begin
              errors++;
              $display("FAIL frame_decode: got frame bits %h, required %h (byte %h)",
                       bits & MASK, model_frame(exp_b) & MASK, exp_b);
            end
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus driver helpers (all run in the posedge+1ns phase)
  // ---------------------------------------------------------------------------
  task automatic push_byte(input logic [7:0] b, output int acc);
    int n;
    n            = 0;
    acc          = -1;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && n < 2 * FRAME) begin
      step(1);
      n++;
    end
    if (bus.tx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: tx_ready=%b, required 1 within %0d clks", bus.tx_ready, 2 * FRAME);
    end else begin
      step(1);
      acc = cyc;
      sb.push_back(b);
    end
  endtask

  task automatic bus_idle();
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
  endtask

  task automatic wait_fall(input string name, output int f);
    int n;
    n = 0;
    while (io_tx !== 1'b0 && n < 2 * FRAME) begin
      step(1);
      n++;
    end
    f = cyc;
    if (io_tx !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s_fall_timeout: io_tx=%b, required 0 within %0d clks", name, io_tx, 2 * FRAME);
    end
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy || tx_busy !== 1'b0) && n < bound) begin
      step(1);
      n++;
    end
    checks++;
    if (sb.size() != 0 || mon_busy || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d tx_busy=%b, required 0 pending and tx_busy=0",
               name, sb.size(), tx_busy);
    end
  endtask

  task automatic check_gaps(input string name, input int n_exp);
    checks++;
    if (fall_q.size() != n_exp) begin
      errors++;
      $display("FAIL %s_frame_count: got %0d frames, required %0d", name, fall_q.size(), n_exp);
    end
    for (int i = 1; i < fall_q.size(); i++) begin
      checks++;
      if (fall_q[i] - fall_q[i-1] != FRAME) begin
        errors++;
        $display("FAIL %s_gap[%0d]: got %0d clks between starts, required %0d",
                 name, i, fall_q[i] - fall_q[i-1], FRAME);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    bus_idle();
    step(5);
    checks += 3;
    if (io_tx !== 1'b1) begin
      errors++; $display("FAIL reset_io_tx: got %b, required 1", io_tx);
    end
    if (tx_busy !== 1'b0) begin
      errors++; $display("FAIL reset_tx_busy: got %b, required 0", tx_busy);
    end
    if (bus.tx_ready !== 1'b1) begin
      errors++; $display("FAIL reset_tx_ready: got %b, required 1", bus.tx_ready);
    end
    reset_n = 1'b1;
    step(5);
    checks++;
    if (io_tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL after_reset_idle: io_tx=%b tx_busy=%b, required 1 and 0", io_tx, tx_busy);
    end
  endtask

  task automatic test_single();
    int          acc;
    int          fall;
    logic [11:0] f;
    f = model_frame(8'h55);
    push_byte(8'h55, acc);
    bus_idle();
    step(1);
    checks += 2;
    if (tx_busy !== 1'b1) begin
      errors++; $display("FAIL single_busy_rise: tx_busy=%b at accept+1, required 1", tx_busy);
    end
    if (io_tx !== 1'b1) begin
      errors++; $display("FAIL single_early_fall: io_tx=%b at accept+1, required 1", io_tx);
    end
    wait_fall("single", fall);
    checks++;
    if (fall - acc != 2) begin
      errors++; $display("FAIL single_latency: io_tx fell %0d clks after accept, required 2", fall - acc);
    end
    for (int k = 0; k < NBITS; k++) begin
      checks++;
      if (io_tx !== f[k]) begin
        errors++; $display("FAIL single_bit%0d_first: io_tx=%b, required %b", k, io_tx, f[k]);
      end
      step(CPB - 1);
      checks++;
      if (io_tx !== f[k]) begin
        errors++; $display("FAIL single_bit%0d_last: io_tx=%b, required %b", k, io_tx, f[k]);
      end
      step(1);
    end
    checks++;
    if (tx_busy !== 1'b0 || io_tx !== 1'b1) begin
      errors++; $display("FAIL single_end: tx_busy=%b io_tx=%b after stop, required 0 and 1", tx_busy, io_tx);
    end
    wait_idle("single", 2 * FRAME);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    int         acc [4];
    bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    fall_q.delete();
    for (int i = 0; i < 4; i++) push_byte(bytes[i], acc[i]);
    bus_idle();
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (acc[i] - acc[0] != i) begin
        errors++; $display("FAIL b2b_accept%0d: accepted %0d clks after first, required %0d", i, acc[i] - acc[0], i);
      end
    end
    wait_idle("b2b", 6 * FRAME);
    check_gaps("b2b", 4);
  endtask

  task automatic test_reset_mid_frame();
    int acc;
    int fall;
    int n;
    push_byte(8'h81, acc);
    bus_idle();
    wait_fall("abort", fall);
    step(4 * CPB);
    @(posedge clk);
    #5;
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (io_tx !== 1'b1) begin
      errors++; $display("FAIL abort_io_tx: got %b right after reset, required 1", io_tx);
    end
    if (tx_busy !== 1'b0) begin
      errors++; $display("FAIL abort_tx_busy: got %b right after reset, required 0", tx_busy);
    end
    if (bus.tx_ready !== 1'b1) begin
      errors++; $display("FAIL abort_tx_ready: got %b right after reset, required 1", bus.tx_ready);
    end
    sb.delete();
    step(3);
    reset_n = 1'b1;
    n = 0;
    while (mon_busy && n < 2 * FRAME) begin
      step(1);
      n++;
    end
    checks++;
    if (io_tx !== 1'b1) begin
      errors++; $display("FAIL abort_line_idle: io_tx=%b after reset, required 1", io_tx);
    end
    fall_q.delete();
    push_byte(8'h42, acc);
    bus_idle();
    wait_idle("abort", 2 * FRAME);
    check_gaps("abort", 1);
    if (fall_q.size() == 1) begin
      checks++;
      if (fall_q[0] - acc != 2) begin
        errors++; $display("FAIL abort_latency: io_tx fell %0d clks after accept, required 2", fall_q[0] - acc);
      end
    end
  endtask

  // Streams a 16-byte file with tx_valid held; covers FIFO-full backpressure.
  task automatic test_stream();
    logic [7:0] file [16];
    int         acc;
    int         fall0;
    int         frames0;
    for (int i = 0; i < 16; i++) file[i] = 8'($urandom_range(0, 255));
    fall_q.delete();
    frames0 = mon_frames;
    push_byte(file[0], acc);
    bus_idle();
    wait_fall("stream", fall0);
    step(CPB / 2);
    for (int i = 1; i <= 4; i++) push_byte(file[i], acc);
    checks++;
    if (bus.tx_ready !== 1'b0) begin
      errors++; $display("FAIL stream_full: tx_ready=%b with 4 stored, required 0", bus.tx_ready);
    end
    push_byte(file[5], acc);
    checks++;
    if (acc != fall0 + FRAME) begin
      errors++; $display("FAIL stream_fifth_accept: accepted at clk %0d, required %0d (after first pop)",
                         acc, fall0 + FRAME);
    end
    for (int i = 6; i < 16; i++) push_byte(file[i], acc);
    bus_idle();
    wait_idle("stream", 8 * FRAME);
    check_gaps("stream", 16);
    checks++;
    if (mon_frames - frames0 != 16) begin
      errors++; $display("FAIL stream_received: got %0d bytes, required 16", mon_frames - frames0);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int acc;
    fall_q.delete();
    par_q.delete();
    push_byte(8'h07, acc);
    push_byte(8'h03, acc);
    bus_idle();
    wait_idle("parity", 4 * FRAME);
    check_gaps("parity", 2);
    if (par_q.size() == 2) begin
      checks += 2;
      if (par_q[0] !== 1'b1) begin
        errors++; $display("FAIL parity_07: got %b, required 1", par_q[0]);
      end
      if (par_q[1] !== 1'b0) begin
        errors++; $display("FAIL parity_03: got %b, required 0", par_q[1]);
      end
    end
    checks++;
    if (FRAME != 11 * 347 || (fall_q.size() == 2 && fall_q[1] - fall_q[0] != 11 * 347)) begin
      errors++; $display("FAIL parity_frame_len: frame is not 11*347 clks");
    end
  endtask
`endif

  initial begin : guard
    repeat (99_000) @(posedge clk);
    $display("FAIL global_timeout: bench still running at cycle %0d, required finish earlier", cyc);
    $fatal(1, "timeout");
  end

  initial begin : main
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
    test_stream();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_tx
